// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full_adder cell walks the operands LSB first, one bit
// per clock, under a three-state IDLE/RUN/DONE controller.

// Single-bit full adder cell.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry_out
);
    assign sum       = a ^ b ^ cin;
    assign carry_out = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int unsigned        CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]   LAST  = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_reg, b_reg, res_reg, res_next;
    logic             carry_reg;
    logic [CNT_W-1:0] cnt;
    logic             fa_sum, fa_co;
    logic             accept;

    full_adder u_fa (
        .a         (a_reg[cnt]),
        .b         (b_reg[cnt]),
        .cin       (carry_reg),
        .sum       (fa_sum),
        .carry_out (fa_co)
    );

    // Next-state logic, start acceptance and status outputs.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (cnt == LAST) state_next = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Partial result with the current bit merged in.
    always_comb begin
        res_next      = res_reg;
        res_next[cnt] = fa_sum;
    end

    // State, operand capture, per-bit accumulation and result publication.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            carry_reg <= 1'b0;
            cnt       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                a_reg     <= a;
                b_reg     <= b;
                carry_reg <= cin;
                cnt       <= '0;
            end else if (state == RUN) begin
                res_reg   <= res_next;
                carry_reg <= fa_co;
                // Counter holds at LAST so it never wraps inside one operation.
                if (cnt == LAST) begin
                    sum  <= res_next;
                    cout <= fa_co;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule
